multi_cycle_ctrl: RTL and testbench



---
 rtl/mc_ctrl_pkg.sv | 73 +++++++
 rtl/mc_opcode_decode.sv | 41 ++++
 rtl/multi_cycle_ctrl.sv | 177 +++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multi-cycle MIPS controller
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BR     = 4'd8,
        S_JMP    = 4'd9,
        S_JALWB  = 4'd10,
        S_TRAP   = 4'd11
    } state_t;

    typedef enum logic [3:0] {
        CL_LOAD,
        CL_STORE,
        CL_R,
        CL_IALU,
        CL_BEQ,
        CL_BNE,
        CL_J,
        CL_JAL,
        CL_ILL
    } op_class_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_OR    = 4'b0010;
    localparam logic [3:0] ALU_SLT   = 4'b0011;
    localparam logic [3:0] ALU_BNE   = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b1010;
    localparam logic [3:0] ALU_LUI   = 4'b1011;
    localparam logic [3:0] ALU_XOR   = 4'b1100;
    localparam logic [3:0] ALU_RTYPE = 4'b1111;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] LS_WORD = 2'b11;
    localparam logic [1:0] LS_BYTE = 2'b01;
    localparam logic [1:0] LS_HALF = 2'b00;

endpackage

// File: rtl/mc_opcode_decode.sv
// mc_opcode_decode: classifies an opcode and supplies its aluop, extension mode and access size
module mc_opcode_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    output op_class_t  cls,
    output logic [3:0] aluop,
    output logic       ext_op,
    output logic [1:0] ls_flag
);

    // opcode lookup; anything unlisted is illegal
    always_comb begin
        cls     = CL_ILL;
        aluop   = ALU_ADD;
        ext_op  = 1'b1;
        ls_flag = LS_HALF;
        case (op)
            OP_LW:    begin cls = CL_LOAD;  ls_flag = LS_WORD; end
            OP_LB:    begin cls = CL_LOAD;  ls_flag = LS_BYTE; end
            OP_LH:    cls = CL_LOAD;
            OP_SW:    begin cls = CL_STORE; ls_flag = LS_WORD; end
            OP_SB:    begin cls = CL_STORE; ls_flag = LS_BYTE; end
            OP_SH:    cls = CL_STORE;
            OP_RTYPE: begin cls = CL_R;     aluop = ALU_RTYPE; end
            OP_ADDI,
            OP_ADDIU: cls = CL_IALU;
            OP_SLTI:  begin cls = CL_IALU;  aluop = ALU_SLT; end
            OP_LUI:   begin cls = CL_IALU;  aluop = ALU_LUI; end
            OP_ANDI:  begin cls = CL_IALU;  aluop = ALU_AND; ext_op = 1'b0; end
            OP_ORI:   begin cls = CL_IALU;  aluop = ALU_OR;  ext_op = 1'b0; end
            OP_XORI:  begin cls = CL_IALU;  aluop = ALU_XOR; ext_op = 1'b0; end
            OP_BEQ:   begin cls = CL_BEQ;   aluop = ALU_SUB; end
            OP_BNE:   begin cls = CL_BNE;   aluop = ALU_BNE; end
            OP_J:     cls = CL_J;
            OP_JAL:   cls = CL_JAL;
            default:  ;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: multi-cycle MIPS sequencer; define MULTI_CYCLE_CTRL_TRAP_EN to trap illegal opcodes
module multi_cycle_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opCode,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       branch,
    output logic       nebranch,
    output logic       iorD,
    output logic       irWrite,
    output logic       memRead,
    output logic       memWrite,
    output logic       memToReg,
    output logic       regDst,
    output logic       regWrite,
    output logic       jal,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [3:0] aluop,
    output logic [1:0] pcSource,
    output logic       ExtOp,
    output logic [1:0] ls_flag,
    output logic [3:0] state
`ifdef MULTI_CYCLE_CTRL_TRAP_EN
    ,
    output logic       illegalOp
`endif
);

`ifdef MULTI_CYCLE_CTRL_TRAP_EN
    localparam state_t ILL_NEXT = S_TRAP;
`else
    localparam state_t ILL_NEXT = S_FETCH;
`endif

    state_t     cur, nxt;
    logic [5:0] op_q;
    logic [5:0] op_dec;
    op_class_t  cls;
    logic [3:0] dec_aluop;
    logic       dec_ext;
    logic [1:0] dec_ls;

    // DECODE must branch on the opcode being latched this very cycle
    assign op_dec = (cur == S_DECODE) ? opCode : op_q;
    assign state  = cur;

    mc_opcode_decode u_dec (
        .op      (op_dec),
        .cls     (cls),
        .aluop   (dec_aluop),
        .ext_op  (dec_ext),
        .ls_flag (dec_ls)
    );

    // state register and opcode capture at the end of DECODE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur  <= S_FETCH;
            op_q <= '0;
        end else begin
            cur <= nxt;
            if (cur == S_DECODE) op_q <= opCode;
        end
    end

    // next state and strobes; everything forced low while reset is held
    always_comb begin
        nxt      = cur;
        pcWrite  = 1'b0;
        branch   = 1'b0;
        nebranch = 1'b0;
        iorD     = 1'b0;
        irWrite  = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        memToReg = 1'b0;
        regDst   = 1'b0;
        regWrite = 1'b0;
        jal      = 1'b0;
        aluSrcA  = 1'b0;
        aluSrcB  = SRCB_B;
        aluop    = ALU_ADD;
        pcSource = PCSRC_ALU;
        ExtOp    = 1'b0;
        ls_flag  = LS_HALF;
`ifdef MULTI_CYCLE_CTRL_TRAP_EN
        illegalOp = 1'b0;
`endif
        if (rst_n) begin
            case (cur)
                S_FETCH: begin
                    memRead = 1'b1;
                    aluSrcB = SRCB_FOUR;
                    irWrite = memReady;
                    pcWrite = memReady;
                    nxt     = memReady ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    aluSrcB = SRCB_IMM_SH;
                    nxt = (cls == CL_LOAD || cls == CL_STORE) ? S_MEMADR :
                          (cls == CL_R    || cls == CL_IALU)  ? S_EXEC   :
                          (cls == CL_BEQ  || cls == CL_BNE)   ? S_BR     :
                          (cls == CL_J)                       ? S_JMP    :
                          (cls == CL_JAL)                     ? S_JALWB  : ILL_NEXT;
                end
                S_MEMADR: begin
                    aluSrcA = 1'b1;
                    aluSrcB = SRCB_IMM;
                    ExtOp   = 1'b1;
                    ls_flag = dec_ls;
                    nxt     = (cls == CL_LOAD) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    memRead = 1'b1;
                    iorD    = 1'b1;
                    ls_flag = dec_ls;
                    nxt     = memReady ? S_MEMWB : S_MEMRD;
                end
                S_MEMWB: begin
                    regWrite = 1'b1;
                    memToReg = 1'b1;
                    nxt      = S_FETCH;
                end
                S_MEMWR: begin
                    memWrite = 1'b1;
                    iorD     = 1'b1;
                    ls_flag  = dec_ls;
                    nxt      = memReady ? S_FETCH : S_MEMWR;
                end
                S_EXEC: begin
                    aluSrcA = 1'b1;
                    aluSrcB = (cls == CL_R) ? SRCB_B : SRCB_IMM;
                    aluop   = dec_aluop;
                    ExtOp   = dec_ext;
                    nxt     = S_ALUWB;
                end
                S_ALUWB: begin
                    regWrite = 1'b1;
                    regDst   = (cls == CL_R);
                    nxt      = S_FETCH;
                end
                S_BR: begin
                    aluSrcA  = 1'b1;
                    pcSource = PCSRC_ALUOUT;
                    aluop    = dec_aluop;
                    branch   = (cls == CL_BEQ);
                    nebranch = (cls == CL_BNE);
                    nxt      = S_FETCH;
                end
                S_JMP: begin
                    pcWrite  = 1'b1;
                    pcSource = PCSRC_JUMP;
                    nxt      = S_FETCH;
                end
                S_JALWB: begin
                    regWrite = 1'b1;
                    jal      = 1'b1;
                    pcWrite  = 1'b1;
                    pcSource = PCSRC_JUMP;
                    nxt      = S_FETCH;
                end
`ifdef MULTI_CYCLE_CTRL_TRAP_EN
                S_TRAP: begin
                    illegalOp = 1'b1;
                    nxt       = S_TRAP;
                end
`endif
                default: nxt = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: directed and randomized checks of the multi-cycle controller against a phase-level model
module tb_multi_cycle_ctrl;
    import mc_ctrl_pkg::*;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       nebranch;
        logic       ior_d;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       jal;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] aluop;
        logic [1:0] pc_source;
        logic       ext_op;
        logic [1:0] ls_flag;
        logic [3:0] state;
    } out_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opCode;
    logic       memReady;
    logic       pcWrite, branch, nebranch, iorD, irWrite, memRead, memWrite;
    logic       memToReg, regDst, regWrite, jal, aluSrcA, ExtOp;
    logic [1:0] aluSrcB, pcSource, ls_flag;
    logic [3:0] aluop, state;
`ifdef MULTI_CYCLE_CTRL_TRAP_EN
    logic       illegalOp;
`endif
    out_t       obs;
    int         total = 0;
    int         bad = 0;
    bit         rnd = 1'b0;
    logic       rdy_q[$];
    state_t     ph[$];

    always #5 clk = ~clk;

    multi_cycle_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .opCode   (opCode),
        .memReady (memReady),
        .pcWrite  (pcWrite),
        .branch   (branch),
        .nebranch (nebranch),
        .iorD     (iorD),
        .irWrite  (irWrite),
        .memRead  (memRead),
        .memWrite (memWrite),
        .memToReg (memToReg),
        .regDst   (regDst),
        .regWrite (regWrite),
        .jal      (jal),
        .aluSrcA  (aluSrcA),
        .aluSrcB  (aluSrcB),
        .aluop    (aluop),
        .pcSource (pcSource),
        .ExtOp    (ExtOp),
        .ls_flag  (ls_flag),
        .state    (state)
`ifdef MULTI_CYCLE_CTRL_TRAP_EN
        ,
        .illegalOp(illegalOp)
`endif
    );

    assign obs = {pcWrite, branch, nebranch, iorD, irWrite, memRead, memWrite, memToReg,
                  regDst, regWrite, jal, aluSrcA, aluSrcB, aluop, pcSource, ExtOp, ls_flag, state};

    function automatic bit is_load(input logic [5:0] op);
        return op inside {6'h20, 6'h21, 6'h23};
    endfunction

    function automatic bit is_store(input logic [5:0] op);
        return op inside {6'h28, 6'h29, 6'h2b};
    endfunction

    function automatic bit is_alu(input logic [5:0] op);
        return op inside {6'h00, 6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f};
    endfunction

    // access size follows the low opcode bits: x11 word, x00 byte, x01 half
    function automatic logic [1:0] size_of(input logic [5:0] op);
        return (op[1:0] == 2'b11) ? 2'b11 : (op[1:0] == 2'b00) ? 2'b01 : 2'b00;
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] op);
        case (op)
            6'h00:   return 4'b1111;
            6'h0a:   return 4'b0011;
            6'h0c:   return 4'b1010;
            6'h0d:   return 4'b0010;
            6'h0e:   return 4'b1100;
            6'h0f:   return 4'b1011;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic out_t exp_out(input state_t p, input logic [5:0] op, input logic r);
        out_t e = '0;
        e.state = p;
        case (p)
            S_FETCH:  begin e.mem_read = 1; e.alu_src_b = 2'd1; e.ir_write = r; e.pc_write = r; end
            S_DECODE: e.alu_src_b = 2'd3;
            S_MEMADR: begin e.alu_src_a = 1; e.alu_src_b = 2'd2; e.ext_op = 1; e.ls_flag = size_of(op); end
            S_MEMRD:  begin e.mem_read = 1; e.ior_d = 1; e.ls_flag = size_of(op); end
            S_MEMWB:  begin e.reg_write = 1; e.mem_to_reg = 1; end
            S_MEMWR:  begin e.mem_write = 1; e.ior_d = 1; e.ls_flag = size_of(op); end
            S_EXEC: begin
                e.alu_src_a = 1;
                e.alu_src_b = (op == 6'h00) ? 2'd0 : 2'd2;
                e.aluop     = alu_of(op);
                e.ext_op    = !(op inside {6'h0c, 6'h0d, 6'h0e});
            end
            S_ALUWB:  begin e.reg_write = 1; e.reg_dst = (op == 6'h00); end
            S_BR: begin
                e.alu_src_a = 1;
                e.pc_source = 2'd1;
                e.aluop     = (op == 6'h04) ? 4'b0001 : 4'b0110;
                e.branch    = (op == 6'h04);
                e.nebranch  = (op == 6'h05);
            end
            S_JMP:    begin e.pc_write = 1; e.pc_source = 2'd2; end
            S_JALWB:  begin e.reg_write = 1; e.jal = 1; e.pc_write = 1; e.pc_source = 2'd2; end
            default:  ;
        endcase
        return e;
    endfunction

    function automatic bit waitable(input state_t p);
        return p inside {S_FETCH, S_MEMRD, S_MEMWR};
    endfunction

    function automatic logic pick(input state_t p);
        if (waitable(p) && rdy_q.size() > 0) return rdy_q.pop_front();
        if (waitable(p)) return rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string tag, input out_t e);
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
        end
`ifdef MULTI_CYCLE_CTRL_TRAP_EN
        total++;
        assert (illegalOp === (e.state == S_TRAP)) else begin
            bad++;
            $error("FAIL %s illegalOp: observed=%b expected=%b", tag, illegalOp, e.state == S_TRAP);
        end
`endif
    endtask

    // one clock: IR value only meaningful in DECODE, garbage elsewhere
    task automatic cyc(input state_t p, input logic [5:0] op, input logic r);
        opCode   = (p == S_DECODE) ? op : 6'($urandom);
        memReady = r;
        @(negedge clk);
        chk(p.name(), exp_out(p, op, r));
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op);
        ph = '{S_FETCH, S_DECODE};
        if (is_load(op))               ph = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB};
        else if (is_store(op))         ph = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWR};
        else if (is_alu(op))           ph = '{S_FETCH, S_DECODE, S_EXEC, S_ALUWB};
        else if (op inside {4, 5})     ph = '{S_FETCH, S_DECODE, S_BR};
        else if (op == 6'h02)          ph = '{S_FETCH, S_DECODE, S_JMP};
        else if (op == 6'h03)          ph = '{S_FETCH, S_DECODE, S_JALWB};
`ifdef MULTI_CYCLE_CTRL_TRAP_EN
        else                           ph = '{S_FETCH, S_DECODE, S_TRAP, S_TRAP, S_TRAP, S_TRAP};
`endif
        for (int i = 0; i < ph.size(); i++) begin
            state_t p;
            logic   r;
            p = ph[i];
            do begin
                r = pick(p);
                cyc(p, op, r);
            end while (waitable(p) && !r);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] ops[$];
        ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0d,
                6'h0e, 6'h0f, 6'h20, 6'h21, 6'h23, 6'h28, 6'h29, 6'h2b};
`ifndef MULTI_CYCLE_CTRL_TRAP_EN
        ops.push_back(6'h3f);
        ops.push_back(6'h10);
        ops.push_back(6'h07);
`endif
        rst_n    = 1'b0;
        opCode   = '0;
        memReady = 1'b1;
        @(negedge clk);
        chk("reset_outputs", '0);
        @(posedge clk);
        #1;
        chk("reset_held", '0);
        memReady = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_instr(6'h00);
        rdy_q = '{1'b1, 1'b0, 1'b0, 1'b1};
        run_instr(6'h23);
        run_instr(6'h05);
        run_instr(6'h03);
        rdy_q = '{1'b0, 1'b1};
        run_instr(6'h28);
        run_instr(6'h0c);
        cyc(S_FETCH, 6'h2b, 1'b1);
        cyc(S_DECODE, 6'h2b, 1'b1);
        cyc(S_MEMADR, 6'h2b, 1'b0);
        opCode   = 6'h23;
        memReady = 1'b0;
        @(negedge clk);
        chk("memwr_wait", exp_out(S_MEMWR, 6'h2b, 1'b0));
        #2 rst_n = 1'b0;
        #1 chk("memwr_abort", '0);
        @(posedge clk);
        #1;
        chk("abort_held", '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_instr(6'h00);
        rnd = 1'b1;
        repeat (60) run_instr(ops[$urandom_range(0, ops.size() - 1)]);
        rnd = 1'b0;
        run_instr(6'h3f);
`ifdef MULTI_CYCLE_CTRL_TRAP_EN
        rst_n = 1'b0;
        #1 chk("trap_reset", '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
`endif
        run_instr(6'h04);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
